// File: rtl/qsgmii_pkg.sv
// Shared QSGMII TX constants and the per-lane symbol record carried through the lane FIFOs.
package qsgmii_pkg;
  localparam int NUM_LANES = 4;

  localparam logic [7:0] K28_5 = 8'hBC;
  localparam logic [7:0] K28_1 = 8'h3C;
  localparam logic [7:0] D16_2 = 8'h50;

  typedef struct packed {
    logic       is_ctl;
    logic       fdn;
    logic [7:0] data;
  } lane_sym_t;
endpackage

// File: rtl/qsgmii_lane_fifo.sv
// Single-clock per-lane symbol FIFO; ready is registered so the port sees no combinational path.
module qsgmii_lane_fifo import qsgmii_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic      tx_clk,
  input  logic      rst_n,
  input  logic      push,
  input  lane_sym_t wdata,
  input  logic      pop,
  output lane_sym_t rdata,
  output logic      empty,
  output logic      ready
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  lane_sym_t         mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count, count_nxt;
  logic              do_push, do_pop;

  // A full FIFO refuses the push even when a pop frees a slot this cycle.
  assign do_push = push & ready;
  assign do_pop  = pop & ~empty;
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + CW'(1);
    else if (do_pop && !do_push) count_nxt = count - CW'(1);
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (count_nxt < CW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge tx_clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/qsgmii_tx_aggregator.sv
// QSGMII transmit combiner: four buffered SGMII lanes merged into one 32-bit word per tx_clk,
// idle-filled when starved, with lane 0 tagged by K28.1 in place of K28.5.
module qsgmii_tx_aggregator import qsgmii_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                   tx_clk,
  input  logic                   rst_n,
  input  logic [NUM_LANES-1:0]   port_valid,
  output logic [NUM_LANES-1:0]   port_ready,
  input  logic [NUM_LANES*8-1:0] port_data,
  input  logic [NUM_LANES-1:0]   port_is_ctl,
  input  logic [NUM_LANES-1:0]   port_force_disparity_negative,
  input  logic                   clear_status,
  output logic [NUM_LANES*8-1:0] tx_data,
  output logic [NUM_LANES-1:0]   tx_data_is_ctl,
  output logic [NUM_LANES-1:0]   tx_force_disparity_negative,
  output logic [NUM_LANES-1:0]   underflow,
  output logic [NUM_LANES-1:0]   marker_err
);
  lane_sym_t            head [NUM_LANES];
  lane_sym_t            sym  [NUM_LANES];
  logic [NUM_LANES-1:0] lane_empty, lane_pop;
  logic [NUM_LANES-1:0] fill_phase, fill_nxt, last_was_data, lwd_nxt;
  logic [NUM_LANES-1:0] uf_set, me_set;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    lane_sym_t wsym;
    assign wsym = '{is_ctl: port_is_ctl[g], fdn: port_force_disparity_negative[g],
                    data: port_data[g*8+:8]};

    qsgmii_lane_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .tx_clk (tx_clk),
      .rst_n  (rst_n),
      .push   (port_valid[g]),
      .wdata  (wsym),
      .pop    (lane_pop[g]),
      .rdata  (head[g]),
      .empty  (lane_empty[g]),
      .ready  (port_ready[g])
    );
  end

  // An idle ordered set is two symbols; once K28.5 is out the D16.2 must follow, queued data or not.
  always_comb begin
    for (int g = 0; g < NUM_LANES; g++) begin
      lane_pop[g] = 1'b0;
      fill_nxt[g] = 1'b0;
      lwd_nxt[g]  = last_was_data[g];
      uf_set[g]   = 1'b0;
      me_set[g]   = 1'b0;
      sym[g]      = '{is_ctl: 1'b0, fdn: 1'b0, data: D16_2};
      if (!fill_phase[g]) begin
        if (!lane_empty[g]) begin
          lane_pop[g] = 1'b1;
          sym[g]      = head[g];
          lwd_nxt[g]  = !head[g].is_ctl;
          if (head[g].is_ctl && head[g].data == K28_1) begin
            sym[g].data = K28_5;
            me_set[g]   = 1'b1;
          end
        end else begin
          sym[g]      = '{is_ctl: 1'b1, fdn: 1'b0, data: K28_5};
          fill_nxt[g] = 1'b1;
          if (last_was_data[g]) begin
            uf_set[g]  = 1'b1;
            lwd_nxt[g] = 1'b0;
          end
        end
      end
      if (g == 0 && sym[g].is_ctl && sym[g].data == K28_5) sym[g].data = K28_1;
    end
  end

  always_ff @(posedge tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_phase                  <= '0;
      last_was_data               <= '0;
      underflow                   <= '0;
      marker_err                  <= '0;
      tx_data                     <= '0;
      tx_data_is_ctl              <= '0;
      tx_force_disparity_negative <= '0;
    end else begin
      fill_phase    <= fill_nxt;
      last_was_data <= lwd_nxt;
      underflow     <= (underflow & ~{NUM_LANES{clear_status}}) | uf_set;
      marker_err    <= (marker_err & ~{NUM_LANES{clear_status}}) | me_set;
      for (int g = 0; g < NUM_LANES; g++) begin
        tx_data[g*8+:8]                <= sym[g].data;
        tx_data_is_ctl[g]              <= sym[g].is_ctl;
        tx_force_disparity_negative[g] <= sym[g].fdn;
      end
    end
  end
endmodule
